// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared definitions:
// FSM state encoding and register addresses.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] IRQ_MASK = 2'd0;
  localparam logic [1:0] IRQ_MODE = 2'd1;
  localparam logic [1:0] IRQ_PEND = 2'd2;
  localparam logic [1:0] IRQ_STAT = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder.
// i_req: request vector; o_valid: any set; o_code: index+1.
module irq_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int GNT_W   = 5
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_valid,
  output logic [GNT_W-1:0]   o_code
);

  // Scan high to low so the lowest set index is written last.
  always_comb begin
    o_valid = 1'b0;
    o_code  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_code  = GNT_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: mask/mode regs, edge detect, FSM.
// Ports: irq_in lines, cfg_* reg port, Ireq/Iack/Ieoi/gntInt CPU port.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int GNT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               Ireq,
  input  logic               Iack,
  input  logic               Ieoi,
  output logic [GNT_W-1:0]   gntInt
);

  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_mode;
  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_irq_qq;
  logic [NUM_IRQ-1:0] r_pend_e;
  irq_state_e         r_state;
  logic               r_ireq;
  logic [GNT_W-1:0]   r_gnt;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_gnt_oh;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_wdata;
  logic               w_wr_pend;
  logic               w_ack;
  logic               w_valid;
  logic [GNT_W-1:0]   w_code;
  logic               w_unused;

  assign w_wdata  = cfg_wdata[NUM_IRQ-1:0];
  assign w_unused = ^cfg_wdata[31:NUM_IRQ];

  // A fresh edge counts as pending in the same cycle
  // it appears, giving edge channels level latency.
  assign w_rise = r_irq_q & ~r_irq_qq & r_mode;
  assign w_pend = (r_mode & (r_pend_e | w_rise))
                | (~r_mode & r_irq_q);
  assign w_elig = w_pend & r_mask;

  assign w_gnt_oh  = NUM_IRQ'(1) << (r_gnt - GNT_W'(1));
  assign w_wr_pend = cfg_we && (cfg_addr == IRQ_PEND);
  assign w_ack     = (r_state == ST_REQ) && Iack;
  assign w_clr     = ({NUM_IRQ{w_wr_pend}} & w_wdata)
                   | ({NUM_IRQ{w_ack}} & w_gnt_oh);

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .GNT_W   (GNT_W)
  ) u_enc (
    .i_req   (w_elig),
    .o_valid (w_valid),
    .o_code  (w_code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask   <= '0;
      r_mode   <= '0;
      r_irq_q  <= '0;
      r_irq_qq <= '0;
      r_pend_e <= '0;
    end else begin
      r_irq_q  <= irq_in;
      r_irq_qq <= r_irq_q;
      // Set beats clear; level bits never hold state.
      r_pend_e <= ((r_pend_e & ~w_clr) | w_rise) & r_mode;
      if (cfg_we && (cfg_addr == IRQ_MASK)) r_mask <= w_wdata;
      if (cfg_we && (cfg_addr == IRQ_MODE)) r_mode <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ireq  <= 1'b0;
      r_gnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state <= ST_REQ;
            r_ireq  <= 1'b1;
            r_gnt   <= w_code;
          end
        end
        ST_REQ: begin
          if (Iack) begin
            r_state <= ST_SERVICE;
            r_ireq  <= 1'b0;
          end else if ((w_elig & w_gnt_oh) == '0) begin
            r_state <= ST_IDLE;
            r_ireq  <= 1'b0;
            r_gnt   <= '0;
          end
        end
        ST_SERVICE: begin
          if (Ieoi) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ireq  <= 1'b0;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      IRQ_MASK: cfg_rdata = 32'(r_mask);
      IRQ_MODE: cfg_rdata = 32'(r_mode);
      IRQ_PEND: cfg_rdata = 32'(w_pend);
      IRQ_STAT: cfg_rdata = 32'({r_gnt, r_state});
      default:  cfg_rdata = '0;
    endcase
  end

  assign Ireq   = r_ireq;
  assign gntInt = r_gnt;

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed plan plus
// randomized run against a behavioural model.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N = 8;
  localparam int G = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_in;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [31:0]   cfg_wdata;
  logic [31:0]   cfg_rdata;
  logic          Ireq;
  logic          Iack;
  logic          Ieoi;
  logic [G-1:0]  gntInt;

  int n_vec  = 0;
  int n_miss = 0;

  irq_ctrl #(.NUM_IRQ(N), .GNT_W(G)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .Ireq      (Ireq),
    .Iack      (Iack),
    .Ieoi      (Ieoi),
    .gntInt    (gntInt)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel bits, phase and grant.
  bit [N-1:0] m_q, m_qq, m_ep, m_mask, m_mode;
  int         m_st, m_gnt;
  bit         m_req;

  function automatic bit [N-1:0] m_pend();
    bit [N-1:0] p;
    for (int i = 0; i < N; i++)
      p[i] = m_mode[i] ? (m_ep[i] || (m_q[i] && !m_qq[i]))
                       : m_q[i];
    return p;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_mask);
      2'd1:    return 32'(m_mode);
      2'd2:    return 32'(m_pend());
      default: return 32'(m_gnt * 4 + m_st);
    endcase
  endfunction

  task automatic model_edge();
    bit [N-1:0] el, nep;
    int  win;
    bit  rise, clr;
    if (reset) begin
      m_q = '0; m_qq = '0; m_ep = '0;
      m_mask = '0; m_mode = '0;
      m_st = 0; m_gnt = 0; m_req = 0;
      return;
    end
    el  = m_pend() & m_mask;
    win = -1;
    for (int i = 0; i < N; i++)
      if (el[i] && win < 0) win = i;
    for (int i = 0; i < N; i++) begin
      rise = m_mode[i] && m_q[i] && !m_qq[i];
      clr  = (cfg_we && cfg_addr == 2'd2 && cfg_wdata[i])
          || (m_st == 1 && Iack && m_gnt == i + 1);
      nep[i] = m_mode[i] && ((m_ep[i] && !clr) || rise);
    end
    if (m_st == 0) begin
      if (win >= 0) begin
        m_st = 1; m_req = 1; m_gnt = win + 1;
      end
    end else if (m_st == 1) begin
      if (Iack) begin
        m_st = 2; m_req = 0;
      end else if (!el[m_gnt-1]) begin
        m_st = 0; m_req = 0; m_gnt = 0;
      end
    end else if (Ieoi) begin
      m_st = 0; m_gnt = 0;
    end
    if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[N-1:0];
    if (cfg_we && cfg_addr == 2'd1) m_mode = cfg_wdata[N-1:0];
    m_qq = m_q;
    m_q  = irq_in;
    m_ep = nep;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [31:0] exp);
    cfg_addr = a;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic out(input string tag, input logic r,
                     input int g);
    chk({tag, "_ireq"}, 32'(Ireq), 32'(r));
    chk({tag, "_gnt"}, 32'(gntInt), 32'(g));
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; cfg_we = 1'b0;
    cfg_addr = 2'd0; cfg_wdata = '0;
    Iack = 1'b0; Ieoi = 1'b0;
    tick(); tick();
    reset = 1'b0;
    out("rst", 1'b0, 0);
    rd("rst_mask", IRQ_MASK, 0);
    rd("rst_stat", IRQ_STAT, 0);

    // Level channel 0 handshake and re-request.
    wr(IRQ_MASK, 32'h01);
    irq_in = 8'h01;
    tick();
    out("lvl_k1", 1'b0, 0);
    tick();
    out("lvl_k2", 1'b1, 1);
    Iack = 1'b1; tick(); Iack = 1'b0;
    out("lvl_ack", 1'b0, 1);
    rd("lvl_stat", IRQ_STAT, 32'h6);
    tick();
    out("lvl_svc", 1'b0, 1);
    Ieoi = 1'b1; tick(); Ieoi = 1'b0;
    out("lvl_eoi", 1'b0, 0);
    tick();
    out("lvl_again", 1'b1, 1);
    irq_in = '0;
    tick(); tick();
    out("lvl_wd", 1'b0, 0);

    // Edge channel 3 pulse.
    wr(IRQ_MASK, 32'h08);
    wr(IRQ_MODE, 32'h08);
    irq_in = 8'h08; tick(); irq_in = '0;
    rd("edg_pend0", IRQ_PEND, 32'h08);
    tick();
    out("edg_req", 1'b1, 4);
    rd("edg_pend1", IRQ_PEND, 32'h08);
    Iack = 1'b1; tick(); Iack = 1'b0;
    out("edg_ack", 1'b0, 4);
    rd("edg_pclr", IRQ_PEND, 32'h0);
    Ieoi = 1'b1; tick(); Ieoi = 1'b0;
    tick(); tick();
    out("edg_none", 1'b0, 0);

    // Fixed priority.
    wr(IRQ_MASK, 32'hFF);
    wr(IRQ_MODE, 32'h00);
    irq_in = 8'h24; tick();
    irq_in = 8'h81; tick();
    out("pri_first", 1'b1, 3);
    Iack = 1'b1; tick(); Iack = 1'b0;
    Ieoi = 1'b1; tick(); Ieoi = 1'b0;
    out("pri_eoi", 1'b0, 0);
    tick();
    out("pri_next", 1'b1, 1);
    Iack = 1'b1; irq_in = '0; tick(); Iack = 1'b0;
    Ieoi = 1'b1; tick(); Ieoi = 1'b0;
    tick();
    out("pri_idle", 1'b0, 0);

    // Withdraw vs. ack on line drop, then reset in SERVICE.
    irq_in = 8'h20; tick(); tick();
    out("wd_req", 1'b1, 6);
    irq_in = '0; tick();
    out("wd_hold", 1'b1, 6);
    tick();
    out("wd_drop", 1'b0, 0);
    irq_in = 8'h20; tick(); tick();
    out("ak_req", 1'b1, 6);
    irq_in = '0; tick();
    Iack = 1'b1; tick(); Iack = 1'b0;
    out("ak_svc", 1'b0, 6);
    rd("ak_stat", IRQ_STAT, 32'h1A);
    reset = 1'b1; tick(); reset = 1'b0;
    out("mid_rst", 1'b0, 0);
    rd("mid_stat", IRQ_STAT, 0);
    rd("mid_mask", IRQ_MASK, 0);

    // W1C racing a new edge on channel 2.
    wr(IRQ_MASK, 32'h04);
    wr(IRQ_MODE, 32'h04);
    irq_in = 8'h04; tick();
    irq_in = '0; tick();
    irq_in = 8'h04; tick();
    wr(IRQ_PEND, 32'h04);
    rd("w1c_race", IRQ_PEND, 32'h04);
    wr(IRQ_PEND, 32'h04);
    rd("w1c_alone", IRQ_PEND, 32'h0);
    tick();
    out("w1c_wd", 1'b0, 0);

    // Randomized run against the model.
    reset = 1'b1; irq_in = '0; tick(); reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) irq_in = N'($urandom);
      Iack      = ($urandom_range(2) == 0);
      Ieoi      = ($urandom_range(3) == 0);
      cfg_we    = ($urandom_range(4) == 0);
      cfg_addr  = 2'($urandom);
      cfg_wdata = $urandom;
      reset     = ($urandom_range(199) == 0);
      tick();
      reset = 1'b0; cfg_we = 1'b0;
      chk("rnd_ireq", 32'(Ireq), 32'(m_req));
      chk("rnd_gnt", 32'(gntInt), 32'(m_gnt));
      cfg_addr = 2'($urandom);
      #1;
      chk("rnd_rd", cfg_rdata, m_read(cfg_addr));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
